// File: rtl/bcd_serial_adder_if.sv
// Handshake and operand/result bundle for the digit-serial BCD adder.
// The requester uses the master modport, the adder uses the slave modport.
interface bcd_serial_adder_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  invalid;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, invalid
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, invalid
    );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder: one decimal digit per clock, LSD first,
// with a start/busy/done handshake and registered sum, carry and invalid flag.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_serial_adder_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic            carry;
    logic [W-1:0]    res_acc;
    logic            inv_acc;

    logic            busy_r;
    logic            done_r;
    logic [W-1:0]    sum_r;
    logic            cout_r;
    logic            invalid_r;

    logic [4:0]      s5;
    logic [4:0]      dig_res;
    logic            carry_nxt;
    logic [W-1:0]    res_nxt;
    logic            inv_nxt;
    logic            last;

    // Decimal correction: carry is taken from the comparison, not from the
    // corrected value, so out-of-range digits still give a defined result.
    function automatic logic [4:0] bcd_correct(input logic [4:0] bin);
        logic [4:0] adj;
        adj = bin + 5'd6;
        if (bin > 5'd9) begin
            bcd_correct = {1'b1, adj[3:0]};
        end else begin
            bcd_correct = {1'b0, bin[3:0]};
        end
    endfunction

    function automatic logic digit_bad(input logic [3:0] d);
        digit_bad = (d > 4'd9);
    endfunction

    // Operands shift right each digit, so the active digit is always at [3:0];
    // result digits enter at the top and reach their own position after DIGITS steps.
    always_comb begin
        s5        = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, carry};
        dig_res   = bcd_correct(s5);
        carry_nxt = dig_res[4];
        res_nxt   = res_acc >> 4;
        res_nxt[W-1 -: 4] = dig_res[3:0];
        inv_nxt   = inv_acc | digit_bad(a_sh[3:0]) | digit_bad(b_sh[3:0]);
        last      = (idx == IW'(DIGITS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            res_acc   <= '0;
            inv_acc   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            sum_r     <= '0;
            cout_r    <= 1'b0;
            invalid_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh    <= bus.a;
                        b_sh    <= bus.b;
                        carry   <= bus.cin;
                        idx     <= '0;
                        res_acc <= '0;
                        inv_acc <= 1'b0;
                        busy_r  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 4;
                    b_sh    <= b_sh >> 4;
                    carry   <= carry_nxt;
                    res_acc <= res_nxt;
                    inv_acc <= inv_nxt;
                    if (last) begin
                        state     <= IDLE;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        sum_r     <= res_nxt;
                        cout_r    <= carry_nxt;
                        invalid_r <= inv_nxt;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.sum     = sum_r;
    assign bus.cout    = cout_r;
    assign bus.invalid = invalid_r;
endmodule
